pu_riscv_biu_ahb3: RTL and testbench

- Bus-interface unit that sits directly downstream of the core's BIU port mux.
- Converts the single arbitrated biu_* request stream into AMBA3 AHB-Lite master transfers.
- Supports single, INCR, INCR4/8/16 and WRAP4/8/16 transfers.
- Pipelines AHB address and data phases, generates per-beat burst addresses, and returns per-beat data, acknowledge and error to the mux.

---
 rtl/pu_riscv_biu_ahb3_pkg.sv | 11 +
 rtl/pu_riscv_biu_ahb3_if.sv | 19 +
 rtl/pu_riscv_biu_ahb3_addr_gen.sv | 16 +
 rtl/pu_riscv_biu_ahb3.sv | 97 +++++++++
 tb/tb_pu_riscv_biu_ahb3.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/pu_riscv_biu_ahb3_pkg.sv
// peripheral_biu_verilog_pkg: AHB3 burst/transfer/response encodings and burst beat-count helper
package peripheral_biu_verilog_pkg;
  localparam logic [2:0] HBURST_SINGLE = 3'd0, HBURST_INCR = 3'd1, HBURST_WRAP4 = 3'd2, HBURST_INCR4 = 3'd3,
                         HBURST_WRAP8 = 3'd4, HBURST_INCR8 = 3'd5, HBURST_WRAP16 = 3'd6, HBURST_INCR16 = 3'd7;
  localparam logic [1:0] HTRANS_IDLE = 2'd0, HTRANS_BUSY = 2'd1, HTRANS_NONSEQ = 2'd2, HTRANS_SEQ = 2'd3;
  localparam logic HRESP_OKAY = 1'b0, HRESP_ERROR = 1'b1;
  // remaining beats after the first: x4 -> 3, x8 -> 7, x16 -> 15, SINGLE/INCR -> 0
  function automatic logic [3:0] type2cnt(input logic [2:0] t);
    return t[2:1] == 2'd3 ? 4'd15 : t[2:1] == 2'd2 ? 4'd7 : t[2:1] == 2'd1 ? 4'd3 : 4'd0;
  endfunction
endpackage

// File: rtl/pu_riscv_biu_ahb3_if.sv
// pu_riscv_biu_ahb3_if: AHB3-Lite master/slave bus signals
interface pu_riscv_biu_ahb3_if #(parameter int XLEN = 64, parameter int PLEN = 64);
  logic            HSEL;
  logic [PLEN-1:0] HADDR;
  logic [XLEN-1:0] HWDATA;
  logic [XLEN-1:0] HRDATA;
  logic            HWRITE;
  logic [2:0]      HSIZE;
  logic [2:0]      HBURST;
  logic [3:0]      HPROT;
  logic [1:0]      HTRANS;
  logic            HMASTLOCK;
  logic            HREADY;
  logic            HRESP;
  modport master(output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK,
                 input HRDATA, HREADY, HRESP);
  modport slave(input HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK,
                output HRDATA, HREADY, HRESP);
endinterface

// File: rtl/pu_riscv_biu_ahb3_addr_gen.sv
// pu_riscv_biu_addr_gen: next burst beat address, incrementing or wrapping on the burst boundary
module pu_riscv_biu_addr_gen
  import peripheral_biu_verilog_pkg::*;
#(parameter int PLEN = 64) (
  input  logic [PLEN-1:0] haddr,
  input  logic [2:0]      hsize,
  input  logic [2:0]      hburst,
  output logic [PLEN-1:0] nxt_addr
);
  logic [PLEN-1:0] inc, mask;
  always_comb begin
    inc      = haddr + (PLEN'(1) << hsize);
    mask     = ((PLEN'(type2cnt(hburst)) + PLEN'(1)) << hsize) - PLEN'(1);
    nxt_addr = (hburst != HBURST_SINGLE && !hburst[0]) ? (haddr & ~mask) | (inc & mask) : inc;
  end
endmodule

// File: rtl/pu_riscv_biu_ahb3.sv
// pu_riscv_biu_ahb3: BIU request stream to AHB3-Lite master bursts; PU_RISCV_BIU_RDATA_REG_EN registers the response outputs
module pu_riscv_biu_ahb3
  import peripheral_biu_verilog_pkg::*;
#(parameter int XLEN = 64, parameter int PLEN = 64) (
  input  logic              rst_ni,
  input  logic              clk_i,
  input  logic              biu_req_i,
  output logic              biu_req_ack_o,
  output logic              biu_d_ack_o,
  input  logic [PLEN-1:0]   biu_adri_i,
  output logic [PLEN-1:0]   biu_adro_o,
  input  logic [2:0]        biu_size_i,
  input  logic [2:0]        biu_type_i,
  input  logic              biu_lock_i,
  input  logic [2:0]        biu_prot_i,
  input  logic              biu_we_i,
  input  logic [XLEN-1:0]   biu_d_i,
  output logic [XLEN-1:0]   biu_q_o,
  output logic              biu_ack_o,
  output logic              biu_err_o,
  pu_riscv_biu_ahb3_if.master ahb
);
  logic [3:0]      cnt;
  logic            err_abort, dp_valid, addr_act, err_first;
  logic [PLEN-1:0] dp_adr, nxt_addr;
  pu_riscv_biu_addr_gen #(.PLEN(PLEN)) u_addr_gen (
    .haddr(ahb.HADDR), .hsize(ahb.HSIZE), .hburst(ahb.HBURST), .nxt_addr(nxt_addr)
  );
  assign addr_act      = ahb.HTRANS == HTRANS_NONSEQ || ahb.HTRANS == HTRANS_SEQ;
  assign biu_req_ack_o = biu_req_i & ahb.HREADY & (cnt == '0) & ~err_abort;
  assign biu_d_ack_o   = ahb.HREADY & addr_act & ahb.HWRITE;
  // first cycle of the two-cycle ERROR response: cancel the pending address phase
  assign err_first     = dp_valid & (ahb.HRESP == HRESP_ERROR) & ~ahb.HREADY;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      ahb.HTRANS    <= HTRANS_IDLE;
      ahb.HSEL      <= 1'b0;
      ahb.HADDR     <= '0;
      ahb.HWDATA    <= '0;
      ahb.HWRITE    <= 1'b0;
      ahb.HSIZE     <= '0;
      ahb.HBURST    <= '0;
      ahb.HPROT     <= '0;
      ahb.HMASTLOCK <= 1'b0;
      cnt           <= '0;
      err_abort     <= 1'b0;
      dp_valid      <= 1'b0;
      dp_adr        <= '0;
    end else if (err_first) begin
      ahb.HTRANS <= HTRANS_IDLE;
      ahb.HSEL   <= 1'b0;
      cnt        <= '0;
      err_abort  <= 1'b1;
    end else if (ahb.HREADY) begin
      err_abort <= 1'b0;
      dp_valid  <= addr_act;
      dp_adr    <= ahb.HADDR;
      if (biu_d_ack_o) ahb.HWDATA <= biu_d_i;
      if (biu_req_ack_o) begin
        ahb.HTRANS    <= HTRANS_NONSEQ;
        ahb.HSEL      <= 1'b1;
        ahb.HADDR     <= biu_adri_i;
        ahb.HSIZE     <= biu_size_i;
        ahb.HBURST    <= biu_type_i;
        ahb.HWRITE    <= biu_we_i;
        ahb.HMASTLOCK <= biu_lock_i;
        ahb.HPROT     <= {1'b0, biu_prot_i};
        cnt           <= type2cnt(biu_type_i);
      end else if (cnt != '0) begin
        ahb.HTRANS <= HTRANS_SEQ;
        ahb.HADDR  <= nxt_addr;
        cnt        <= cnt - 4'd1;
      end else begin
        ahb.HTRANS <= HTRANS_IDLE;
        ahb.HSEL   <= 1'b0;
      end
    end
`ifdef PU_RISCV_BIU_RDATA_REG_EN
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      biu_ack_o  <= 1'b0;
      biu_err_o  <= 1'b0;
      biu_q_o    <= '0;
      biu_adro_o <= '0;
    end else begin
      biu_ack_o  <= dp_valid & ahb.HREADY & (ahb.HRESP == HRESP_OKAY);
      biu_err_o  <= dp_valid & ahb.HREADY & (ahb.HRESP == HRESP_ERROR);
      biu_q_o    <= ahb.HRDATA;
      biu_adro_o <= dp_adr;
    end
`else
  assign biu_ack_o  = dp_valid & ahb.HREADY & (ahb.HRESP == HRESP_OKAY);
  assign biu_err_o  = dp_valid & ahb.HREADY & (ahb.HRESP == HRESP_ERROR);
  assign biu_q_o    = ahb.HRDATA;
  assign biu_adro_o = dp_adr;
`endif
endmodule

// File: tb/tb_pu_riscv_biu_ahb3.sv
// tb_pu_riscv_biu_ahb3: directed burst vectors plus back-to-back, error and mid-burst reset sequences
module tb_pu_riscv_biu_ahb3;
  import peripheral_biu_verilog_pkg::*;
  typedef struct {
    logic [63:0] adr;
    logic [2:0]  sz;
    logic [2:0]  typ;
    logic        we;
    int          nb;
    int          wb;
    int          eb;
    int          eo;
  } vec_t;
  logic clk = 0, rst_ni = 0;
  logic biu_req = 0, biu_req_ack, biu_d_ack, biu_lock = 0, biu_we = 0, biu_ack, biu_err;
  logic [63:0] biu_adri = 0, biu_adro, biu_d = 0, biu_q;
  logic [2:0] biu_size = 0, biu_type = 0, biu_prot = 0;
  int n_chk = 0, n_fail = 0;
  vec_t tbl[8];
  logic [63:0] ea[$];
  pu_riscv_biu_ahb3_if #(.XLEN(64), .PLEN(64)) ahb();
  pu_riscv_biu_ahb3 #(.XLEN(64), .PLEN(64)) dut (
    .rst_ni(rst_ni), .clk_i(clk), .biu_req_i(biu_req), .biu_req_ack_o(biu_req_ack), .biu_d_ack_o(biu_d_ack),
    .biu_adri_i(biu_adri), .biu_adro_o(biu_adro), .biu_size_i(biu_size), .biu_type_i(biu_type),
    .biu_lock_i(biu_lock), .biu_prot_i(biu_prot), .biu_we_i(biu_we), .biu_d_i(biu_d), .biu_q_o(biu_q),
    .biu_ack_o(biu_ack), .biu_err_o(biu_err), .ahb(ahb)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask
  function automatic logic [63:0] rdat(input int t, input int i);
    return {32'hC0DE0000 + 32'(t), 32'h00005000 + 32'(i)};
  endfunction
  function automatic logic [63:0] wdat(input int t, input int i);
    return {32'hBEEF0000 + 32'(t), 32'h0000A000 + 32'(i)};
  endfunction
  task automatic run_vec(input int t);
    vec_t v;
    int ai, di;
    bit waited, done, dp;
    v = tbl[t]; ai = 0; di = 0; waited = 0; done = 0;
    biu_req = 1; biu_adri = v.adr; biu_size = v.sz; biu_type = v.typ; biu_we = v.we; biu_prot = 3'b011;
    ahb.HREADY = 1; ahb.HRESP = 0;
    #1 chk("req_ack", 64'(biu_req_ack), 64'd1);
    @(posedge clk); #1 biu_req = 0;
    for (int c = 0; c < 40 && !done && (ai < v.nb || di < ai); c++) begin
      dp = di < ai;
      if (dp && di == v.eb) begin
        ahb.HREADY = 0; ahb.HRESP = 1; #1;
        chk("err_w_ack", 64'(biu_ack), 64'd0);
        chk("err_w_err", 64'(biu_err), 64'd0);
        @(posedge clk); #1;
        chk("err_idle", 64'(ahb.HTRANS), 64'(HTRANS_IDLE));
        ahb.HREADY = 1; biu_req = 1; #1;
        chk("err_err", 64'(biu_err), 64'd1);
        chk("err_ack", 64'(biu_ack), 64'd0);
        chk("err_block", 64'(biu_req_ack), 64'd0);
        biu_req = 0;
        @(posedge clk); #1 ahb.HRESP = 0; #1;
        chk("err_after_idle", 64'(ahb.HTRANS), 64'(HTRANS_IDLE));
        chk("err_once", 64'(biu_err), 64'd0);
        chk("err_noack", 64'(biu_ack), 64'd0);
        done = 1;
      end else begin
        ahb.HREADY = !(dp && di == v.wb && !waited);
        ahb.HRDATA = rdat(t, di); biu_d = wdat(t, ai);
        #1;
        if (ai < v.nb) begin
          chk("htrans", 64'(ahb.HTRANS), ai == 0 ? 64'(HTRANS_NONSEQ) : 64'(HTRANS_SEQ));
          chk("haddr", ahb.HADDR, ea[v.eo + ai]);
          chk("hsize", 64'(ahb.HSIZE), 64'(v.sz));
          chk("hburst", 64'(ahb.HBURST), 64'(v.typ));
          chk("hwrite", 64'(ahb.HWRITE), 64'(v.we));
          if (ai == 0) begin
            chk("hsel", 64'(ahb.HSEL), 64'd1);
            chk("hprot", 64'(ahb.HPROT), 64'h3);
          end
        end else chk("htrans_idle", 64'(ahb.HTRANS), 64'(HTRANS_IDLE));
        chk("d_ack", 64'(biu_d_ack), 64'(ahb.HREADY && ai < v.nb && v.we));
        chk("ack", 64'(biu_ack), 64'(dp && ahb.HREADY));
        chk("err", 64'(biu_err), 64'd0);
        if (dp && ahb.HREADY) begin
          chk("adro", biu_adro, ea[v.eo + di]);
          if (!v.we) chk("q", biu_q, rdat(t, di));
        end
        if (dp && v.we) chk("hwdata", ahb.HWDATA, wdat(t, di));
        @(posedge clk); #1;
        if (ahb.HREADY) begin
          if (dp) di++;
          if (ai < v.nb) ai++;
        end else waited = 1;
      end
    end
    chk("burst_done", 64'(done || (ai == v.nb && di == ai)), 64'd1);
    ahb.HREADY = 1; ahb.HRESP = 0;
  endtask
  initial begin
    tbl[0] = '{64'h1000, 3'd3, HBURST_SINGLE, 1'b0, 1, -1, -1, 0};
    tbl[1] = '{64'h1018, 3'd3, HBURST_WRAP4, 1'b0, 4, -1, -1, 1};
    tbl[2] = '{64'h2000, 3'd2, HBURST_INCR8, 1'b1, 8, 2, -1, 5};
    tbl[3] = '{64'h5000, 3'd3, HBURST_INCR4, 1'b0, 4, -1, 1, 13};
    tbl[4] = '{64'h1004, 3'd2, HBURST_SINGLE, 1'b1, 1, -1, -1, 15};
    tbl[5] = '{64'h6034, 3'd2, HBURST_WRAP8, 1'b0, 8, -1, -1, 16};
    tbl[6] = '{64'h7000, 3'd3, HBURST_INCR, 1'b0, 1, -1, -1, 24};
    tbl[7] = '{64'h80FE, 3'd0, HBURST_WRAP16, 1'b1, 16, -1, -1, 25};
    ea = '{64'h1000,
           64'h1018, 64'h1000, 64'h1008, 64'h1010,
           64'h2000, 64'h2004, 64'h2008, 64'h200C, 64'h2010, 64'h2014, 64'h2018, 64'h201C,
           64'h5000, 64'h5008,
           64'h1004,
           64'h6034, 64'h6038, 64'h603C, 64'h6020, 64'h6024, 64'h6028, 64'h602C, 64'h6030,
           64'h7000,
           64'h80FE, 64'h80FF, 64'h80F0, 64'h80F1, 64'h80F2, 64'h80F3, 64'h80F4, 64'h80F5,
           64'h80F6, 64'h80F7, 64'h80F8, 64'h80F9, 64'h80FA, 64'h80FB, 64'h80FC, 64'h80FD};
    ahb.HREADY = 1; ahb.HRESP = 0; ahb.HRDATA = 0;
    #1;
    chk("rst_htrans", 64'(ahb.HTRANS), 64'(HTRANS_IDLE));
    chk("rst_hsel", 64'(ahb.HSEL), 64'd0);
    chk("rst_haddr", ahb.HADDR, 64'd0);
    chk("rst_hwdata", ahb.HWDATA, 64'd0);
    chk("rst_ack", 64'(biu_ack), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_ni = 1;
    for (int t = 0; t < 8; t++) run_vec(t);
    // back-to-back single writes
    biu_req = 1; biu_adri = 64'h3000; biu_size = 3'd3; biu_type = HBURST_SINGLE; biu_we = 1;
    #1 chk("b2b_ack0", 64'(biu_req_ack), 64'd1);
    @(posedge clk); #1 biu_adri = 64'h3008; biu_d = 64'hD0; #1;
    chk("b2b_ns0", 64'(ahb.HTRANS), 64'(HTRANS_NONSEQ));
    chk("b2b_a0", ahb.HADDR, 64'h3000);
    chk("b2b_ack1", 64'(biu_req_ack), 64'd1);
    chk("b2b_dack0", 64'(biu_d_ack), 64'd1);
    @(posedge clk); #1 biu_req = 0; biu_d = 64'hD1; #1;
    chk("b2b_ns1", 64'(ahb.HTRANS), 64'(HTRANS_NONSEQ));
    chk("b2b_a1", ahb.HADDR, 64'h3008);
    chk("b2b_r0", 64'(biu_ack), 64'd1);
    chk("b2b_adro0", biu_adro, 64'h3000);
    chk("b2b_wd0", ahb.HWDATA, 64'hD0);
    chk("b2b_dack1", 64'(biu_d_ack), 64'd1);
    @(posedge clk); #2;
    chk("b2b_idle", 64'(ahb.HTRANS), 64'(HTRANS_IDLE));
    chk("b2b_r1", 64'(biu_ack), 64'd1);
    chk("b2b_adro1", biu_adro, 64'h3008);
    chk("b2b_wd1", ahb.HWDATA, 64'hD1);
    @(posedge clk); #2;
    chk("b2b_end", 64'(biu_ack), 64'd0);
    // reset in the middle of an INCR16 read
    biu_req = 1; biu_adri = 64'h4000; biu_size = 3'd3; biu_type = HBURST_INCR16; biu_we = 0;
    #1 chk("r16_ack", 64'(biu_req_ack), 64'd1);
    @(posedge clk); #1 biu_req = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("r16_seq", 64'(ahb.HTRANS), 64'(HTRANS_SEQ));
    chk("r16_addr", ahb.HADDR, 64'h4018);
    #2 rst_ni = 0; #1;
    chk("r16_rst_htrans", 64'(ahb.HTRANS), 64'(HTRANS_IDLE));
    chk("r16_rst_hsel", 64'(ahb.HSEL), 64'd0);
    chk("r16_rst_haddr", ahb.HADDR, 64'd0);
    chk("r16_rst_ack", 64'(biu_ack), 64'd0);
    chk("r16_rst_err", 64'(biu_err), 64'd0);
    @(posedge clk); #1 rst_ni = 1;
    run_vec(0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
